sobel_stream_param: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge detector. Successor to the fixed sobel_top_sim datapath.

---
 rtl/sobel_stream_param.sv | 177 +++++++++++++++++
 tb/tb_sobel_stream_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, interior edge pixels out, with frame
// markers and a runtime choice between saturated magnitude and binary threshold output.
module sobel_stream_param #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             mode,
  input  logic [PIX_W+2:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 4;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, pix_row;
  logic [CW-1:0]   col_q, col_d, pix_col;
  logic            ready_en, adv, accept, store, produce, err_d;

  // Valid/ready: a beat transfers on a rising edge where valid & ready are both 1. The whole
  // pipeline moves only when adv=1 (output empty or being taken), and s_ready is exactly adv.
  assign adv     = !m_valid || m_ready;
  assign s_ready = ready_en && adv;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_row = row_q;
    pix_col = col_q;
    store   = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (s_sof) begin
        store   = 1'b1;
        pix_row = '0;
        pix_col = '0;
        err_d   = (state_q == RUN);
        state_d = RUN;
        row_d   = '0;
        col_d   = CW'(1);
      end else if (state_q == RUN) begin
        store = 1'b1;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(IMG_H - 1)) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
    produce = store && (pix_row >= RW'(2)) && (pix_col >= CW'(2));
  end

  // Line buffers and window hold pixel data only; they need no reset.
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];

  always_ff @(posedge clk) begin
    if (store) begin
      lb1[pix_col] <= lb0[pix_col];
      lb0[pix_col] <= s_data;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1[pix_col];
      win[1][2] <= lb0[pix_col];
      win[2][2] <= s_data;
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay, mag;

  assign gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
  assign gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  assign ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
  assign mag = ax + ay;

  logic             w_valid, w_sof, w_eol, w_mode;
  logic [PIX_W+2:0] w_th;
  logic             v1, sof1, eol1, mode1;
  logic [PIX_W+2:0] th1;
  logic [GW-1:0]    mag1;
  logic [PIX_W-1:0] out_val;

  always_comb begin
    out_val = '0;
    if (mode1) out_val = (mag1 >= {1'b0, th1}) ? '1 : '0;
    else if (|mag1[GW-1:PIX_W]) out_val = '1;
    else out_val = mag1[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ready_en  <= 1'b0;
      frame_err <= 1'b0;
      w_valid   <= 1'b0;
      w_sof     <= 1'b0;
      w_eol     <= 1'b0;
      w_mode    <= 1'b0;
      w_th      <= '0;
      v1        <= 1'b0;
      sof1      <= 1'b0;
      eol1      <= 1'b0;
      mode1     <= 1'b0;
      th1       <= '0;
      mag1      <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ready_en  <= 1'b1;
      frame_err <= err_d;
      if (adv) begin
        w_valid <= produce;
        w_sof   <= produce && (pix_row == RW'(2)) && (pix_col == CW'(2));
        w_eol   <= produce && (pix_col == CW'(IMG_W - 1));
        w_mode  <= mode;
        w_th    <= thresh;
        v1      <= w_valid;
        sof1    <= w_sof;
        eol1    <= w_eol;
        mode1   <= w_mode;
        th1     <= w_th;
        mag1    <= mag;
        m_valid <= v1;
        if (v1) begin
          m_data <= out_val;
          m_sof  <= sof1;
          m_eol  <= eol1;
        end else begin
          m_sof <= 1'b0;
          m_eol <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_param.sv
// Bench for sobel_stream_param on a 5x4 image: table of step-edge frames, random frames against
// an arithmetic Sobel model, backpressure, stray/mid-frame start-of-frame and async reset.
module tb_sobel_stream_param;
  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk, rst, s_valid, s_ready, s_sof, mode;
  logic          m_valid, m_ready, m_sof, m_eol, frame_err;
  logic [PW-1:0] s_data, m_data;
  logic [PW+2:0] thresh;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  int err_cycles = 0;
  int mr_mode = 0;
  bit rdy_chk = 0;
  bit gap_en = 0;
  logic [9:0] exp_q[$];
  logic [7:0] frame [H][W];
  logic       stall_prev = 0;
  logic [9:0] stall_val;

  typedef struct {
    string      name;
    logic [7:0] lo;
    logic [7:0] hi;
    int         step;
    logic       md;
    logic [10:0] th;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;
  vec_t vecs[8];

  sobel_stream_param #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .mode(mode), .thresh(thresh), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .frame_err(frame_err)
  );

  // clock and sink-ready generation
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0: m_ready = 1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("stall_hold", {m_valid, m_sof, m_eol, m_data}, {1'b1, stall_val});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none at %0t", {m_sof, m_eol, m_data}, $time);
        end else begin
          chk("out_sof_eol_data", {m_sof, m_eol, m_data}, exp_q.pop_front());
        end
        out_cnt++;
      end
      stall_prev = m_valid && !m_ready;
      stall_val  = {m_sof, m_eol, m_data};
      if (rdy_chk) chk("s_ready_adv", s_ready, !m_valid || m_ready);
      if (frame_err) err_cycles++;
    end
  end

  // driver tasks
  task automatic drive_pix(input logic [7:0] d, input logic sof);
    int n = 0;
    bit done = 0;
    s_valid = 1;
    s_data  = d;
    s_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1;
      else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL drive_timeout: s_ready stuck 0 for %0d cycles", n);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_valid = 0;
    s_sof   = 0;
  endtask

  task automatic gap();
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixels(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      gap();
      drive_pix(frame[i / W][i % W], i == 0);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_left_in_queue"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic int px(input int r, input int c);
    return int'(frame[r][c]);
  endfunction

  // reference model: Sobel on every interior pixel of the stored frame
  task automatic push_model(input logic md, input logic [10:0] th);
    int gx, gy, mg;
    logic [7:0] d;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1)) - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1)) - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        mg = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md) d = (mg >= int'(th)) ? 8'hFF : 8'h00;
        else d = (mg > 255) ? 8'hFF : 8'(mg);
        exp_q.push_back({(r == 1 && c == 1), (c == W - 2), d});
      end
    end
  endtask

  task automatic random_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_sof"}, m_sof, 0);
    chk({tag, "_m_eol"}, m_eol, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  task automatic do_reset(input string tag);
    rdy_chk = 0;
    @(posedge clk);
    #3;
    rst = 0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk({tag, "_s_ready_before_clk"}, s_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_s_ready_first_clk"}, s_ready, 1);
    rdy_chk = 1;
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int start_cnt, start_err;
    s_valid = 0; s_data = 0; s_sof = 0; mode = 0; thresh = 0; rst = 0;
    #12;
    check_reset_outputs("power_on");
    do_reset("reset");

    //             name        lo     hi     step md th      e(col1) e(col2) e(col3)
    vecs[0] = '{"uniform",    8'h50, 8'h50, 3, 0, 11'h000, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{"vstep_ff",   8'h00, 8'hFF, 3, 0, 11'h000, 8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{"thr_low",    8'h00, 8'h10, 3, 1, 11'h080, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{"thr_high",   8'h00, 8'h30, 3, 1, 11'h080, 8'h00, 8'hFF, 8'hFF};
    vecs[4] = '{"thr_equal",  8'h00, 8'h20, 3, 1, 11'h080, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{"mag_unsat",  8'h00, 8'h20, 3, 0, 11'h000, 8'h00, 8'h80, 8'h80};
    vecs[6] = '{"step_col1",  8'h00, 8'hFF, 1, 0, 11'h000, 8'hFF, 8'h00, 8'h00};
    vecs[7] = '{"falling",    8'hFF, 8'h00, 3, 0, 11'h000, 8'h00, 8'hFF, 8'hFF};

    foreach (vecs[i]) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) frame[r][c] = (c >= vecs[i].step) ? vecs[i].hi : vecs[i].lo;
      mode = vecs[i].md;
      thresh = vecs[i].th;
      for (int r = 1; r <= H - 2; r++) begin
        exp_q.push_back({(r == 1), 1'b0, vecs[i].e0});
        exp_q.push_back({1'b0, 1'b0, vecs[i].e1});
        exp_q.push_back({1'b0, 1'b1, vecs[i].e2});
      end
      start_cnt = out_cnt;
      send_pixels(0, W * H - 1);
      drain(vecs[i].name);
      chk({vecs[i].name, "_output_count"}, out_cnt - start_cnt, (W - 2) * (H - 2));
    end

    // latency: first window pixel (2,2) accepted at edge N -> m_valid after edge N+2
    random_frame();
    mode = 0;
    push_model(0, 0);
    send_pixels(0, 2 * W + 1);
    drive_pix(frame[2][2], 0);
    chk("latency_n", m_valid, 0);
    @(posedge clk); #1;
    chk("latency_n1", m_valid, 0);
    @(posedge clk); #1;
    chk("latency_n2", m_valid, 1);
    send_pixels(2 * W + 3, W * H - 1);
    drain("latency");

    // same random frame with m_ready held, then toggling 1010...
    random_frame();
    push_model(0, 0);
    send_pixels(0, W * H - 1);
    drain("rand_ready1");
    mr_mode = 1;
    push_model(0, 0);
    send_pixels(0, W * H - 1);
    drain("rand_toggle");

    // random frames, random mode/threshold, random backpressure and input gaps
    mr_mode = 2;
    gap_en = 1;
    for (int k = 0; k < 6; k++) begin
      random_frame();
      mode = 1'($urandom_range(0, 1));
      thresh = 11'($urandom_range(0, 600));
      start_cnt = out_cnt;
      push_model(mode, thresh);
      send_pixels(0, W * H - 1);
      drain("rand_mixed");
      chk("rand_output_count", out_cnt - start_cnt, (W - 2) * (H - 2));
    end
    gap_en = 0;
    mr_mode = 0;
    mode = 0;

    // stray pixels before s_sof, then s_sof again at pixel 7 of a frame
    chk("frame_err_none_yet", err_cycles, 0);
    for (int i = 0; i < 3; i++) drive_pix(8'($urandom_range(0, 255)), 0);
    random_frame();
    send_pixels(0, 6);
    random_frame();
    start_cnt = out_cnt;
    start_err = err_cycles;
    push_model(0, 0);
    drive_pix(frame[0][0], 1);
    chk("frame_err_pulse", frame_err, 1);
    send_pixels(1, W * H - 1);
    drain("restart");
    chk("restart_output_count", out_cnt - start_cnt, (W - 2) * (H - 2));
    chk("frame_err_cycles", err_cycles - start_err, 1);

    // reset between edges while an output is stalled mid-frame
    mr_mode = 3;
    random_frame();
    send_pixels(0, 2 * W + 2);
    repeat (3) @(posedge clk);
    #1;
    chk("stalled_before_reset", m_valid, 1);
    do_reset("midframe");
    mr_mode = 0;
    for (int i = 0; i < 2; i++) drive_pix(8'($urandom_range(0, 255)), 0);
    random_frame();
    start_cnt = out_cnt;
    push_model(0, 0);
    send_pixels(0, W * H - 1);
    drain("after_reset");
    chk("after_reset_output_count", out_cnt - start_cnt, (W - 2) * (H - 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
